// File: rtl/mem_1rw_port_arb.sv
// mem_1rw_port_arb: merges a write channel and a read channel onto one 1RW
// memory port. Read data returns through a small credit-managed response
// FIFO, so backpressure on the response side never drops a word.
module mem_1rw_port_arb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 48,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write request channel
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_oob_o,
    // read request channel
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    // read response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    // memory RW port
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_en_o,
    output logic                  mem_wmode_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    // Round-robin pointer remembers which channel won the last contended cycle.
    typedef enum logic {
        RR_WRITE = 1'b0,
        RR_READ  = 1'b1
    } rr_e;

    rr_e                   rr_q, rr_d;
    logic                  wr_gnt, rd_gnt;
    logic                  rd_elig;
    logic                  wr_in_range, rd_in_range;
    logic [CNT_W:0]        credit_used;

    logic                  inflight_q, inflight_oob_q;
    logic                  wr_oob_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
    logic                  fifo_err_q  [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_in_range = int'(wr_addr_i) < DEPTH;
    assign rd_in_range = int'(rd_addr_i) < DEPTH;

    // Credit counts words already queued plus the one still in the memory;
    // both are registered, so rsp_ready never reaches rd_ready combinationally.
    assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign rd_elig     = rd_valid_i && (credit_used < (CNT_W+1)'(RSP_DEPTH));

    // Arbitration: single requester wins outright, contention alternates.
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        rr_d   = rr_q;
        if (rst_n) begin
            if (wr_valid_i && rd_elig) begin
                if (rr_q == RR_WRITE) begin
                    rd_gnt = 1'b1;
                    rr_d   = RR_READ;
                end else begin
                    wr_gnt = 1'b1;
                    rr_d   = RR_WRITE;
                end
            end else begin
                wr_gnt = wr_valid_i;
                rd_gnt = rd_elig;
            end
        end
    end

    assign wr_ready_o  = wr_gnt;
    assign rd_ready_o  = rd_gnt;

    // Out-of-range grants complete the handshake but never touch the memory.
    assign mem_en_o    = (wr_gnt && wr_in_range) || (rd_gnt && rd_in_range);
    assign mem_wmode_o = wr_gnt && wr_in_range;
    assign mem_addr_o  = wr_gnt ? wr_addr_i : rd_addr_i;
    assign mem_wdata_o = wr_data_i;
    assign wr_oob_o    = wr_oob_q;

    // The read issued last cycle lands in the FIFO this cycle.
    assign push        = inflight_q;
    assign pop         = (count_q != '0) && rsp_ready_i;

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: arbiter pointer, read pipeline tag, OOB pulse, FIFO pointers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q           <= RR_WRITE;
            inflight_q     <= 1'b0;
            inflight_oob_q <= 1'b0;
            wr_oob_q       <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            rr_q           <= rr_d;
            inflight_q     <= rd_gnt;
            inflight_oob_q <= rd_gnt && !rd_in_range;
            wr_oob_q       <= wr_gnt && !wr_in_range;
            count_q        <= count_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Response storage; an OOB read stores zero data with the error tag set.
    // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= inflight_oob_q ? '0 : mem_rdata_i;
            fifo_err_q[wr_ptr_q]  <= inflight_oob_q;
        end
    end

    assign rsp_valid_o = (count_q != '0);
    assign rsp_data_o  = fifo_data_q[rd_ptr_q];
    assign rsp_err_o   = fifo_err_q[rd_ptr_q];

    // The credit rule guarantees a free slot whenever a read result arrives.
    push_never_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q != CNT_W'(RSP_DEPTH)));

endmodule
